sysreg_access_ctrl: RTL

- Sequences every system-register access: pipeline MTS/MFS instructions and debug-port requests.
- Arbitrates between the two requesters, checks privilege, drives a single-outstanding request/ack sysreg bus, and returns read data or a fault.
- Sits between the decode/execute stage and the system-register file; it is the only master of the sysreg bus.

---
 rtl/sysreg_access_ctrl_pkg.sv | 28 ++
 rtl/sysreg_access_ctrl_arb.sv | 22 ++
 rtl/sysreg_access_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sysreg_access_ctrl_pkg.sv
// sysreg_access_ctrl_pkg: sysreg id layout, instruction decode helpers, FSM and fault types
package sysreg_access_ctrl_pkg;
  localparam logic [7:0] OP_MFS = 8'b0000_1100;
  localparam logic [7:0] OP_MTS = 8'b0000_1101;
  typedef struct packed {
    logic [2:0] num;
    logic [1:0] pl;
    logic [4:0] group;
  } sysreg_id_s;
  typedef union packed {
    logic [9:0] raw;
    sysreg_id_s f;
  } sysreg_id_u;
  typedef enum logic [1:0] {IDLE, CHECK, BUS, RESP} state_e;
  typedef enum logic [2:0] {F_NONE, F_ILLEGAL, F_PRIV, F_BUS_ERR, F_TIMEOUT} fault_e;
  function automatic logic is_mts(input logic [31:0] insn);
    return insn[31:23] == 9'd0 && insn[7:0] == OP_MTS;
  endfunction
  function automatic logic is_mfs(input logic [31:0] insn);
    return insn[31:23] == 9'd0 && insn[7:0] == OP_MFS;
  endfunction
  function automatic logic [4:0] insn_rd(input logic [31:0] insn);
    return insn[22:18];
  endfunction
  function automatic sysreg_id_u insn_sysreg(input logic [31:0] insn);
    return insn[17:8];
  endfunction
endpackage

// File: rtl/sysreg_access_ctrl_arb.sv
// sysreg_req_arb: two-requester arbiter, debug favoured unless it won last time
module sysreg_req_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pipe_valid,
  input  logic dbg_valid,
  output logic gnt_pipe,
  output logic gnt_dbg
);
  logic last_dbg_q, last_dbg_d;
  // grant selection and fairness flag update
  always_comb begin
    gnt_dbg = en && dbg_valid && !(pipe_valid && last_dbg_q);
    gnt_pipe = en && pipe_valid && !gnt_dbg;
    last_dbg_d = gnt_dbg ? 1'b1 : gnt_pipe ? 1'b0 : last_dbg_q;
  end
  // fairness flag register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_dbg_q <= 1'b0;
    else last_dbg_q <= last_dbg_d;
endmodule

// File: rtl/sysreg_access_ctrl.sv
// sysreg_access_ctrl: arbitrates pipeline/debug sysreg accesses, checks privilege, drives the sysreg bus
module sysreg_access_ctrl
  import sysreg_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cur_pl,
  input  logic              pipe_valid,
  input  logic [31:0]       pipe_insn,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_ready,
  output logic              pipe_done,
  output logic [4:0]        pipe_rd,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_fault,
  input  logic              dbg_valid,
  input  logic              dbg_write,
  input  logic [9:0]        dbg_id,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_fault,
  output logic              sr_req,
  output logic              sr_write,
  output logic [9:0]        sr_id,
  output logic [DATA_W-1:0] sr_wdata,
  input  logic              sr_ack,
  input  logic [DATA_W-1:0] sr_rdata,
  input  logic              sr_err
);
  localparam int CW = $clog2(TIMEOUT);
  state_e state_q, state_d;
  fault_e cause_q, cause_d, check_f;
  sysreg_id_u id_q, id_d;
  logic [31:0] insn_q, insn_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic owner_dbg_q, owner_dbg_d, write_q, write_d;
  logic pipe_done_q, pipe_done_d, dbg_done_q, dbg_done_d;
  logic pipe_fault_q, pipe_fault_d, dbg_fault_q, dbg_fault_d;
  logic gnt_pipe, gnt_dbg, expire, done;

  sysreg_req_arb u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state_q == IDLE),
    .pipe_valid (pipe_valid),
    .dbg_valid  (dbg_valid),
    .gnt_pipe   (gnt_pipe),
    .gnt_dbg    (gnt_dbg)
  );

  assign expire = cnt_q == CW'(TIMEOUT - 1);
  assign pipe_ready = gnt_pipe;
  assign dbg_ready = gnt_dbg;
  assign sr_req = state_q == BUS;
  assign sr_write = write_q;
  assign sr_id = id_q.raw;
  assign sr_wdata = wdata_q;
  assign pipe_done = pipe_done_q;
  assign pipe_fault = pipe_fault_q;
  assign pipe_rd = pipe_done_q ? insn_rd(insn_q) : 5'd0;
  assign pipe_rdata = pipe_done_q ? rdata_q : '0;
  assign dbg_done = dbg_done_q;
  assign dbg_fault = dbg_fault_q;
  assign dbg_rdata = dbg_done_q ? rdata_q : '0;

  // access sequencing: capture on grant, check, bus wait with timeout, respond
  always_comb begin
    state_d = state_q;
    owner_dbg_d = owner_dbg_q;
    insn_d = insn_q;
    id_d = id_q;
    write_d = write_q;
    wdata_d = wdata_q;
    cause_d = cause_q;
    cnt_d = '0;
    rdata_d = '0;
    done = 1'b0;
    check_f = !owner_dbg_q && !(is_mts(insn_q) || is_mfs(insn_q)) ? F_ILLEGAL :
              !owner_dbg_q && cur_pl > id_q.f.pl ? F_PRIV : F_NONE;
    case (state_q)
      IDLE: if (gnt_pipe || gnt_dbg) begin
        state_d = CHECK;
        owner_dbg_d = gnt_dbg;
        insn_d = gnt_pipe ? pipe_insn : insn_q;
        id_d = gnt_dbg ? dbg_id : insn_sysreg(pipe_insn);
        write_d = gnt_dbg ? dbg_write : is_mts(pipe_insn);
        wdata_d = gnt_dbg ? dbg_wdata : pipe_wdata;
        cause_d = F_NONE;
      end
      CHECK: begin
        done = check_f != F_NONE;
        cause_d = check_f;
        state_d = done ? RESP : BUS;
      end
      BUS: begin
        done = sr_ack || expire;
        cnt_d = cnt_q + 1'b1;
        cause_d = !done ? cause_q : sr_ack ? (sr_err ? F_BUS_ERR : F_NONE) : F_TIMEOUT;
        rdata_d = sr_ack && !sr_err && !write_q ? sr_rdata : '0;
        state_d = done ? RESP : BUS;
      end
      default: state_d = IDLE;
    endcase
    pipe_done_d = done && !owner_dbg_q;
    dbg_done_d = done && owner_dbg_q;
    pipe_fault_d = pipe_done_d && cause_d != F_NONE;
    dbg_fault_d = dbg_done_d && cause_d != F_NONE;
  end

  // state, captured request and registered response outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_dbg_q <= 1'b0;
      insn_q <= '0;
      id_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cause_q <= F_NONE;
      cnt_q <= '0;
      rdata_q <= '0;
      pipe_done_q <= 1'b0;
      dbg_done_q <= 1'b0;
      pipe_fault_q <= 1'b0;
      dbg_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_dbg_q <= owner_dbg_d;
      insn_q <= insn_d;
      id_q <= id_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      pipe_done_q <= pipe_done_d;
      dbg_done_q <= dbg_done_d;
      pipe_fault_q <= pipe_fault_d;
      dbg_fault_q <= dbg_fault_d;
    end
endmodule
